gate_bist_checker: RTL and testbench
====================================

// Module: gate_bist_checker
// PURPOSE
//  Self-checking stimulus/response engine for the basic gate library (AND_gate_4bit, OR_gate_1bit,
//  NAND_gate_1bit). Generates LFSR operand vectors, drives them to the gate instances, waits a
//  settle window, samples the gate outputs, compares them against internally computed expected
//  values and accumulates a pass/fail result. It is the synthesizable checking counterpart to
//  the gate stimulus benches, used as on-chip BIST for the gate block.
// PARAMETERS
//  WIDTH          4        operand width driven to the multi-bit AND gate (1..8)
//  NUM_VECTORS    16       vectors applied per run (1..256)
//  SETTLE_CYCLES  1        cycles stim is held before outputs are sampled (>=1)
//  LFSR_SEED      16'hACE1 LFSR value loaded on reset and on each accepted start; must be nonzero
//  CNT_W          8        width of err_count (saturating)
// PORTS
//  clk             in   1        single clock, all state updates on posedge
//  rst_n           in   1        asynchronous, active-low reset
//  start           in   1        run request; sampled only in IDLE or DONE
//  stim_a          out  WIDTH    operand A to gates (1-bit gates take stim_a[0])
//  stim_b          out  WIDTH    operand B to gates (1-bit gates take stim_b[0])
//  and_y           in   WIDTH    AND gate result
//  or_y            in   1        OR gate result
//  nand_y          in   1        NAND gate result
//  busy            out  1        high from accepted start until done
//  done            out  1        level; high after last check until next accepted start
//  pass            out  1        valid when done: 1 iff err_count==0
//  err_count       out  CNT_W    number of failing vectors, saturates at all-ones
//  first_fail_idx  out  8        index of first failing vector; 8'hFF if none
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; lfsr=LFSR_SEED; stim_a=stim_b=0; busy=0; done=0;
//   pass=0; err_count=0; first_fail_idx=8'hFF; vec_idx=0; settle_cnt=0.
//  FSM: IDLE -> APPLY on start. DONE -> APPLY on start (clears done/pass/err_count/first_fail_idx,
//   reloads LFSR_SEED, vec_idx=0). start ignored in APPLY/SETTLE/CHECK.
//   APPLY (1 cyc): stim_a=lfsr[WIDTH-1:0], stim_b=lfsr[2*WIDTH-1:WIDTH]; settle_cnt=0 -> SETTLE.
//   SETTLE: hold stim; settle_cnt++; after SETTLE_CYCLES cycles -> CHECK.
//   CHECK (1 cyc): sample and_y/or_y/nand_y vs expected: and_y==stim_a&stim_b,
//    or_y==stim_a[0]|stim_b[0], nand_y==~(stim_a[0]&stim_b[0]). Any mismatch = one failing
//    vector: err_count+1 (saturating); if first failure, first_fail_idx=vec_idx.
//    LFSR advances one step. If vec_idx==NUM_VECTORS-1 -> DONE, else vec_idx++ -> APPLY.
//   DONE: busy=0, done=1, pass=(err_count==0); stim held at last vector.
//  Cycles per vector = SETTLE_CYCLES+2; start accepted at edge T -> done high at
//   T + NUM_VECTORS*(SETTLE_CYCLES+2). Default: 48 cycles.
//  LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left, new bit in [0]; never reaches 0.
//  Boundaries: NUM_VECTORS=1 -> single APPLY/SETTLE/CHECK then DONE. err_count saturates, never
//   wraps. Simultaneous start and final CHECK: start ignored. rst_n low mid-run: immediate return to
//   reset values, no partial result retained; start held high across reset release starts a run
//   on the first clock edge after release.
// STRUCTURE
//  Package gate_bist_pkg: state enum (IDLE, APPLY, SETTLE, CHECK, DONE), LFSR tap mask constant,
//   FAIL_IDX_NONE=8'hFF.
//  One sub-module: gate_bist_lfsr (16-bit, load/step enables, seed parameter). FSM, counters and
//   compare stay in the top.
// TESTING
//  1 Ideal gate models wired back, start pulse -> done at +48 cycles, pass=1, err_count=0, idx=8'hFF.
//  2 and_y[2] forced stuck-at-0 -> pass=0, err_count = count of vectors with a[2]&b[2]=1,
//    first_fail_idx = first such index (golden LFSR model in bench).
//  3 nand_y inverted on all vectors, CNT_W=4, NUM_VECTORS=32 -> err_count=4'hF (saturated), idx=0.
//  4 start re-pulsed during SETTLE of vector 3 -> ignored; done still at +48 from original start.
//  5 rst_n low at cycle 20 of a run -> all outputs at reset values asynchronously; new start
//    gives same stim sequence from LFSR_SEED (first stim_a=4'h1, stim_b=4'hE).
//  6 NUM_VECTORS=1, SETTLE_CYCLES=3 -> done 5 cycles after start; second start from DONE reruns cleanly.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-library BIST checker.
package gate_bist_pkg;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [7:0]  FAIL_IDX_NONE = 8'hFF;

endpackage

// File: rtl/gate_bist_lfsr.sv
// 16-bit Fibonacci LFSR operand source; shifts left with the new bit entering at [0].
module gate_bist_lfsr
  import gate_bist_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [OUT_W-1:0] value
);

  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign value = lfsr[OUT_W-1:0];

endmodule

// File: rtl/gate_bist_checker.sv
// On-chip stimulus/response checker for the AND/OR/NAND gate block.
// Each vector: APPLY (1) + SETTLE (SETTLE_CYCLES) + CHECK (1) cycles.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int          WIDTH         = 4,
  parameter int          NUM_VECTORS   = 16,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] stim_a,
  output logic [WIDTH-1:0] stim_b,
  input  logic [WIDTH-1:0] and_y,
  input  logic             or_y,
  input  logic             nand_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       first_fail_idx
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_t               state, state_next;
  logic [7:0]           vec_idx;
  logic [SW-1:0]        settle_cnt;
  logic [2*WIDTH-1:0]   lfsr_val;
  logic                 start_ok;
  logic                 last_vec;
  logic                 settle_end;
  logic                 mismatch;

  assign start_ok   = start && (state == IDLE || state == DONE);
  assign last_vec   = (vec_idx == 8'(NUM_VECTORS - 1));
  assign settle_end = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign mismatch   = (and_y != (stim_a & stim_b)) ||
                      (or_y != (stim_a[0] | stim_b[0])) ||
                      (nand_y != ~(stim_a[0] & stim_b[0]));

  gate_bist_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (2*WIDTH)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .step  (state == CHECK),
    .value (lfsr_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = APPLY;
      APPLY:   state_next = SETTLE;
      SETTLE:  if (settle_end) state_next = CHECK;
      CHECK:   state_next = last_vec ? DONE : APPLY;
      DONE:    if (start) state_next = APPLY;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_a         <= '0;
      stim_b         <= '0;
      err_count      <= '0;
      first_fail_idx <= FAIL_IDX_NONE;
      vec_idx        <= '0;
      settle_cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            err_count      <= '0;
            first_fail_idx <= FAIL_IDX_NONE;
            vec_idx        <= '0;
          end
        end
        APPLY: begin
          stim_a     <= lfsr_val[WIDTH-1:0];
          stim_b     <= lfsr_val[2*WIDTH-1:WIDTH];
          settle_cnt <= '0;
        end
        SETTLE: settle_cnt <= settle_cnt + SW'(1);
        CHECK: begin
          // err_count==0 doubles as the "no failure yet" flag, even once saturated.
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
            if (err_count == '0) first_fail_idx <= vec_idx;
          end
          if (!last_vec) vec_idx <= vec_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == APPLY) || (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_gate_bist_checker.sv
// Scoreboard bench: expected run results are queued at start; monitors compare on done rising.
module tb_gate_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic stuck  = 1'b0;

  // dut0: defaults, optional and_y[2] stuck-at-0
  logic [3:0] sa0, sb0, and0;
  logic       or0, nand0, busy0, done0, pass0;
  logic [7:0] err0, idx0;
  assign and0  = (sa0 & sb0) & ~(stuck ? 4'b0100 : 4'b0000);
  assign or0   = sa0[0] | sb0[0];
  assign nand0 = ~(sa0[0] & sb0[0]);

  // dut1: 32 vectors, 4-bit counter, NAND output inverted
  logic [3:0] sa1, sb1, and1;
  logic       or1, nand1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [7:0] idx1;
  assign and1  = sa1 & sb1;
  assign or1   = sa1[0] | sb1[0];
  assign nand1 = sa1[0] & sb1[0];

  // dut2: single vector, 3 settle cycles
  logic [3:0] sa2, sb2, and2;
  logic       or2, nand2, busy2, done2, pass2;
  logic [7:0] err2, idx2;
  assign and2  = sa2 & sb2;
  assign or2   = sa2[0] | sb2[0];
  assign nand2 = ~(sa2[0] & sb2[0]);

  gate_bist_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stim_a(sa0), .stim_b(sb0),
    .and_y(and0), .or_y(or0), .nand_y(nand0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .first_fail_idx(idx0));

  gate_bist_checker #(.NUM_VECTORS(32), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stim_a(sa1), .stim_b(sb1),
    .and_y(and1), .or_y(or1), .nand_y(nand1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_fail_idx(idx1));

  gate_bist_checker #(.NUM_VECTORS(1), .SETTLE_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stim_a(sa2), .stim_b(sb2),
    .and_y(and2), .or_y(or2), .nand_y(nand2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .first_fail_idx(idx2));

  typedef struct {
    logic       pass;
    logic [7:0] err;
    logic [7:0] idx;
    int         cyc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(int d, logic p, logic [7:0] e, logic [7:0] i, int c);
    exp_t x;
    x.pass = p; x.err = e; x.idx = i; x.cyc = c;
    case (d)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic mon(int d, logic p, logic [7:0] e, logic [7:0] i);
    exp_t x;
    if (qsize(d) == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_unexpected_done: got done with empty scoreboard", d);
    end else begin
      case (d)
        0:       x = q0.pop_front();
        1:       x = q1.pop_front();
        default: x = q2.pop_front();
      endcase
      chk($sformatf("dut%0d_pass", d),      32'(p),   32'(x.pass));
      chk($sformatf("dut%0d_err", d),       32'(e),   32'(x.err));
      chk($sformatf("dut%0d_first_idx", d), 32'(i),   32'(x.idx));
      chk($sformatf("dut%0d_done_cyc", d),  32'(cyc), 32'(x.cyc));
    end
  endtask

  logic d0q = 1'b0, d1q = 1'b0, d2q = 1'b0;
  always @(posedge clk) begin
    #1;
    if (done0 && !d0q) mon(0, pass0, err0, idx0);
    d0q = done0;
  end
  always @(posedge clk) begin
    #1;
    if (done1 && !d1q) mon(1, pass1, {4'h0, err1}, idx1);
    d1q = done1;
  end
  always @(posedge clk) begin
    #1;
    if (done2 && !d2q) mon(2, pass2, err2, idx2);
    d2q = done2;
  end

  task automatic set_start(int d, logic v);
    case (d)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic pulse_start(int d, output int acc);
    @(negedge clk);
    set_start(d, 1'b1);
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    set_start(d, 1'b0);
  endtask

  task automatic wait_empty(int d, int budget);
    for (int k = 0; k < budget && qsize(d) != 0; k++) @(negedge clk);
    chk($sformatf("dut%0d_drain", d), 32'(qsize(d)), 32'd0);
  endtask

  task automatic chk_reset0(string tag);
    chk({tag, "_stim_a"}, 32'(sa0),   32'h0);
    chk({tag, "_stim_b"}, 32'(sb0),   32'h0);
    chk({tag, "_busy"},   32'(busy0), 32'h0);
    chk({tag, "_done"},   32'(done0), 32'h0);
    chk({tag, "_pass"},   32'(pass0), 32'h0);
    chk({tag, "_err"},    32'(err0),  32'h0);
    chk({tag, "_idx"},    32'(idx0),  32'hFF);
  endtask

  // Golden LFSR for x^16+x^14+x^13+x^11+1, shift left, new bit at [0]
  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  int         acc;
  int         m_err;
  logic [7:0] m_idx;
  logic [15:0] lv;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset0("reset");
    chk("reset_dut1_err", 32'(err1), 32'h0);
    chk("reset_dut2_idx", 32'(idx2), 32'hFF);
    @(negedge clk) rst_n = 1'b1;

    // Test 1: ideal gates
    pulse_start(0, acc);
    push(0, 1'b1, 8'h00, 8'hFF, acc + 48);
    chk("t1_busy", 32'(busy0), 32'h1);
    wait_empty(0, 100);

    // Test 2: and_y[2] stuck-at-0
    m_err = 0; m_idx = 8'hFF; lv = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      if (lv[2] & lv[6]) begin
        if (m_err == 0) m_idx = 8'(i);
        m_err++;
      end
      lv = lfsr_next(lv);
    end
    stuck = 1'b1;
    pulse_start(0, acc);
    push(0, (m_err == 0), 8'(m_err), m_idx, acc + 48);
    chk("t2_done_cleared", 32'(done0), 32'h0);
    chk("t2_busy", 32'(busy0), 32'h1);
    wait_empty(0, 100);
    stuck = 1'b0;

    // Test 4: start re-pulsed during SETTLE of vector 3
    pulse_start(0, acc);
    push(0, 1'b1, 8'h00, 8'hFF, acc + 48);
    repeat (10) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 chk("t4_busy_after_restart", 32'(busy0), 32'h1);
    @(negedge clk) start0 = 1'b0;
    wait_empty(0, 100);

    // Test 5: reset mid-run, start held across release
    pulse_start(0, acc);
    repeat (19) @(negedge clk);
    rst_n  = 1'b0;
    start0 = 1'b1;
    #1 chk_reset0("t5_async");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    chk("t5_start_over_release", 32'(busy0), 32'h1);
    @(negedge clk) start0 = 1'b0;
    push(0, 1'b1, 8'h00, 8'hFF, acc + 48);
    @(posedge clk);
    #1;
    chk("t5_first_stim_a", 32'(sa0), 32'h1);
    chk("t5_first_stim_b", 32'(sb0), 32'hE);
    wait_empty(0, 100);

    // Test 3: NAND inverted on every vector, saturating 4-bit counter
    pulse_start(1, acc);
    push(1, 1'b0, 8'h0F, 8'h00, acc + 96);
    wait_empty(1, 200);

    // Test 6: single vector, rerun from DONE
    pulse_start(2, acc);
    push(2, 1'b1, 8'h00, 8'hFF, acc + 5);
    wait_empty(2, 50);
    pulse_start(2, acc);
    push(2, 1'b1, 8'h00, 8'hFF, acc + 5);
    chk("t6_rerun_busy", 32'(busy2), 32'h1);
    wait_empty(2, 50);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
